// File: rtl/radio_pkg.sv
// radio_pkg: shared FSM state type and default parameter values for the radio deserializer
package radio_pkg;
  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} lock_state_t;
  localparam int FRAME_BITS_DEF = 8;
  localparam int LOCK_COUNT_DEF = 4;
  localparam int LOSS_COUNT_DEF = 2;
endpackage

// File: rtl/radio_frame_lock.sv
// radio_frame_lock: frame alignment FSM with bit position, good-boundary and miss counters
module radio_frame_lock
  import radio_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int LOSS_COUNT = LOSS_COUNT_DEF,
  localparam int BW = $clog2(FRAME_BITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync,
  output logic [BW-1:0] bit_cnt,
  output logic          locked,
  output logic          lock_next,
  output logic          bad
);
  lock_state_t state, state_n;
  logic [BW-1:0] cnt_n, wrap;
  logic [3:0] good, good_n, miss, miss_n;
  logic bnd;
  assign bnd = bit_cnt == '0;
  assign wrap = (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
  assign locked = state == ST_LOCKED;
  assign lock_next = state_n == ST_LOCKED;
  // State and counter registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_HUNT;
      bit_cnt <= '0;
      good <= '0;
      miss <= '0;
    end else begin
      state <= state_n;
      bit_cnt <= cnt_n;
      good <= good_n;
      miss <= miss_n;
    end
  // Next state: hunt for a marker, verify it repeats, then hold lock until misses pile up
  always_comb begin
    state_n = state;
    cnt_n = bit_cnt;
    good_n = good;
    miss_n = miss;
    bad = 1'b0;
    case (state)
      ST_HUNT: if (sync) begin
        state_n = ST_VERIFY;
        cnt_n = BW'(1);
        good_n = '0;
      end
      ST_VERIFY: begin
        cnt_n = wrap;
        if (bnd && sync) begin
          good_n = good + 4'd1;
          if (good_n == 4'(LOCK_COUNT)) begin
            state_n = ST_LOCKED;
            miss_n = '0;
          end
        end else if (bnd || sync) state_n = ST_HUNT;
      end
      default: begin
        cnt_n = wrap;
        bad = bnd ^ sync;
        if (bnd && sync) miss_n = '0;
        else if (bad) begin
          miss_n = miss + 4'd1;
          if (miss_n == 4'(LOSS_COUNT)) state_n = ST_HUNT;
        end
      end
    endcase
  end
endmodule

// File: rtl/radio_deserializer.sv
// radio_deserializer: serial-to-parallel frame receiver with sync-marker lock and error counting
module radio_deserializer
  import radio_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int LOSS_COUNT = LOSS_COUNT_DEF
) (
  input  logic                  FAST_CLK,
  input  logic                  RST,
  input  logic                  DATA_IN,
  input  logic                  SYNC_IN,
  input  logic                  ERR_CLR,
  output logic [FRAME_BITS-1:0] DATA_WORD,
  output logic                  DATA_VALID,
  output logic                  FRAME_ERR,
  output logic                  LOCKED,
  output logic [15:0]           SYNC_ERR_CNT
);
  localparam int BW = $clog2(FRAME_BITS);
  logic data_r, sync_r, lock_next, bad, done, err_acc, err_done, strobe;
  logic [BW-1:0] bit_cnt;
  logic [FRAME_BITS-1:0] shift;
  radio_frame_lock #(
    .FRAME_BITS(FRAME_BITS),
    .LOCK_COUNT(LOCK_COUNT),
    .LOSS_COUNT(LOSS_COUNT)
  ) u_lock (
    .clk(FAST_CLK),
    .rst(RST),
    .sync(sync_r),
    .bit_cnt(bit_cnt),
    .locked(LOCKED),
    .lock_next(lock_next),
    .bad(bad)
  );
  assign strobe = done && lock_next;
  // Input retiming: every decision uses these registered copies
  always_ff @(posedge FAST_CLK or posedge RST)
    if (RST) begin
      data_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      data_r <= DATA_IN;
      sync_r <= SYNC_IN;
    end
  // Continuous LSB-first shift; flag the last bit of a locked frame and any bad event inside it
  always_ff @(posedge FAST_CLK or posedge RST)
    if (RST) begin
      shift <= '0;
      done <= 1'b0;
      err_acc <= 1'b0;
      err_done <= 1'b0;
    end else begin
      shift <= {data_r, shift[FRAME_BITS-1:1]};
      done <= LOCKED && bit_cnt == BW'(FRAME_BITS - 1);
      err_acc <= (bit_cnt == '0 ? 1'b0 : err_acc) | bad;
      err_done <= err_acc | bad;
    end
  // Publish the word a cycle later, dropped if lock is being lost on this boundary
  always_ff @(posedge FAST_CLK or posedge RST)
    if (RST) begin
      DATA_WORD <= '0;
      DATA_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      DATA_VALID <= strobe;
      FRAME_ERR <= strobe && err_done;
      if (strobe) DATA_WORD <= shift;
    end
  // Saturating bad-boundary counter; clear wins over a same-cycle increment
  always_ff @(posedge FAST_CLK or posedge RST)
    if (RST) SYNC_ERR_CNT <= '0;
    else SYNC_ERR_CNT <= ERR_CLR ? '0 : SYNC_ERR_CNT + 16'(bad && SYNC_ERR_CNT != '1);
endmodule

// File: tb/tb_radio_deserializer.sv
// tb_radio_deserializer: directed frame sequences checking lock, strobes, errors and reset
module tb_radio_deserializer;
  logic clk = 1'b0, rst = 1'b1, data_in = 1'b0, sync_in = 1'b0, err_clr = 1'b0;
  logic [7:0] data_word, vw;
  logic data_valid, frame_err, locked, vf, lk1;
  logic [15:0] err_cnt;
  int total = 0, n_bad = 0, nv, vp, nacc;
  always #5 clk = ~clk;
  radio_deserializer dut (
    .FAST_CLK(clk),
    .RST(rst),
    .DATA_IN(data_in),
    .SYNC_IN(sync_in),
    .ERR_CLR(err_clr),
    .DATA_WORD(data_word),
    .DATA_VALID(data_valid),
    .FRAME_ERR(frame_err),
    .LOCKED(locked),
    .SYNC_ERR_CNT(err_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One frame LSB first; s = marker on bit 0, xs = extra marker bit, fp = bit whose edge sees a
  // forced 0xFFFF error count, cp = bit with ERR_CLR high. Records the strobe seen in this frame.
  task automatic send(input logic [7:0] w, input logic s, input int xs, input int fp, input int cp);
    nv = 0;
    vp = -1;
    vw = 8'h00;
    vf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_in = w[i];
      sync_in = (i == 0) ? s : (i == xs);
      err_clr = (i == cp);
      if (i == fp) force dut.SYNC_ERR_CNT = 16'hFFFF;
      @(negedge clk);
      if (i == fp) release dut.SYNC_ERR_CNT;
      if (data_valid) begin
        nv++;
        vp = i;
        vw = data_word;
        vf = frame_err;
      end
      if (i == 1) lk1 = locked;
    end
    err_clr = 1'b0;
    sync_in = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_word", data_word, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_locked", locked, 0);
    chk("rst_errcnt", err_cnt, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    nacc = 0;
    for (int k = 0; k < 4; k++) begin
      send(8'(k), 1'b1, -1, -1, -1);
      nacc += nv;
    end
    chk("verify_not_locked", locked, 0);
    send(8'd4, 1'b1, -1, -1, -1);
    nacc += nv;
    chk("lock_4th_good", lk1, 1);
    chk("no_valid_before_lock", nacc, 0);
    send(8'd5, 1'b1, -1, -1, -1);
    chk("first_word", vw, 8'h04);
    chk("first_ferr", vf, 0);
    chk("valid_latency", vp, 1);
    chk("one_strobe", nv, 1);
    send(8'd6, 1'b1, -1, -1, -1);
    chk("word5", vw, 8'h05);
    chk("word_hold", data_word, 8'h05);
    send(8'd7, 1'b0, -1, -1, -1);
    chk("word6", vw, 8'h06);
    chk("word6_ferr", vf, 0);
    chk("miss1_errcnt", err_cnt, 1);
    chk("miss1_locked", locked, 1);
    send(8'd8, 1'b1, -1, -1, -1);
    chk("word7", vw, 8'h07);
    chk("word7_ferr", vf, 1);
    send(8'd9, 1'b1, -1, -1, -1);
    chk("word8", vw, 8'h08);
    chk("word8_ferr", vf, 0);
    send(8'd10, 1'b0, -1, -1, -1);
    chk("word9", vw, 8'h09);
    chk("miss_a_locked", locked, 1);
    chk("miss_a_errcnt", err_cnt, 2);
    send(8'd11, 1'b0, -1, -1, -1);
    chk("loss_no_valid", nv, 0);
    chk("loss_at_boundary", lk1, 0);
    chk("loss_errcnt", err_cnt, 3);
    send(8'd12, 1'b0, -1, -1, -1);
    chk("hunt_no_valid", nv, 0);
    chk("hunt_errcnt", err_cnt, 3);
    nacc = 0;
    send(8'd13, 1'b1, -1, -1, -1);
    nacc += nv;
    send(8'd14, 1'b1, -1, -1, -1);
    nacc += nv;
    send(8'd15, 1'b1, 3, -1, -1);
    nacc += nv;
    for (int k = 16; k < 20; k++) begin
      send(8'(k), 1'b1, -1, -1, -1);
      nacc += nv;
    end
    chk("reverify_not_locked", locked, 0);
    send(8'd20, 1'b1, -1, -1, -1);
    nacc += nv;
    chk("relock", lk1, 1);
    chk("reverify_no_valid", nacc, 0);
    chk("verify_errcnt", err_cnt, 3);
    send(8'd21, 1'b1, -1, -1, -1);
    chk("word20", vw, 8'h14);
    chk("word20_ferr", vf, 0);
    chk("word20_latency", vp, 1);
    send(8'd22, 1'b0, -1, 1, -1);
    chk("sat_hold", err_cnt, 16'hFFFF);
    chk("word21", vw, 8'h15);
    chk("sat_locked", locked, 1);
    send(8'd23, 1'b1, 3, -1, -1);
    chk("word22_ferr", vf, 1);
    chk("sat_extra_sync", err_cnt, 16'hFFFF);
    send(8'd24, 1'b1, 3, -1, 4);
    chk("word23", vw, 8'h17);
    chk("word23_ferr", vf, 1);
    chk("clr_wins", err_cnt, 0);
    chk("clr_locked", locked, 1);
    send(8'd25, 1'b1, 5, -1, -1);
    chk("word24", vw, 8'h18);
    chk("count_after_clr", err_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      data_in = 1'(8'd26 >> i);
      sync_in = (i == 0);
      @(negedge clk);
    end
    sync_in = 1'b0;
    chk("pre_rst_locked", locked, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_word", data_word, 0);
    chk("mid_rst_valid", data_valid, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_errcnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    nacc = 0;
    for (int k = 27; k < 31; k++) begin
      send(8'(k), 1'b1, -1, -1, -1);
      nacc += nv;
    end
    chk("post_rst_not_locked", locked, 0);
    send(8'd31, 1'b1, -1, -1, -1);
    nacc += nv;
    chk("post_rst_lock", lk1, 1);
    chk("post_rst_no_valid", nacc, 0);
    send(8'd32, 1'b1, -1, -1, -1);
    chk("post_rst_word", vw, 8'h1F);
    chk("post_rst_ferr", vf, 0);
    chk("post_rst_latency", vp, 1);
    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end
endmodule

// File: doc/radio_deserializer.md
RADIO_DESERIALIZER -- requirements
Module: radio_deserializer

Interface
REQ-001 The block SHALL expose parameters, one per line:
  FRAME_BITS  8  bits per serial frame, 2..16, LSB first
  LOCK_COUNT  4  consecutive good frame boundaries needed to lock, 1..15
  LOSS_COUNT  2  consecutive bad frame boundaries needed to drop lock, 1..15
REQ-002 The block SHALL expose ports, one per line:
  FAST_CLK      input   1           serial bit clock; the only clock
  RST           input   1           asynchronous, active-high reset
  DATA_IN       input   1           serial data, one bit per FAST_CLK
  SYNC_IN       input   1           frame marker, high during bit 0
  ERR_CLR       input   1           synchronous clear of SYNC_ERR_CNT
  DATA_WORD     output  FRAME_BITS  reassembled frame, bit 0 = first bit received
  DATA_VALID    output  1           one-cycle strobe qualifying DATA_WORD
  FRAME_ERR     output  1           qualifies DATA_WORD: frame ended on a bad boundary
  LOCKED        output  1           frame alignment held
  SYNC_ERR_CNT  output  16          saturating count of bad boundaries while LOCKED

Function
REQ-003 DATA_IN and SYNC_IN SHALL be registered once on entry; all decisions SHALL use the registered copies.
REQ-004 A bit counter (width clog2(FRAME_BITS)) SHALL track position in frame; a boundary is bit counter == 0.
REQ-005 FSM states: HUNT, VERIFY, LOCKED.
REQ-006 HUNT: on registered SYNC high, bit counter SHALL load 1, good count 0, next state VERIFY; otherwise stay.
REQ-007 VERIFY: at a boundary with SYNC high, good count SHALL increment; reaching LOCK_COUNT SHALL enter LOCKED.
REQ-008 VERIFY: boundary with SYNC low, or SYNC high off-boundary, SHALL return to HUNT; an off-boundary SYNC in VERIFY SHALL not itself restart VERIFY.
REQ-009 LOCKED: bit counter SHALL free-run modulo FRAME_BITS and SHALL never realign on SYNC.
REQ-010 LOCKED: boundary without SYNC, or SYNC off-boundary, SHALL count as one bad event per cycle; each bad event increments miss count and SYNC_ERR_CNT.
REQ-011 LOCKED: a good boundary SHALL clear miss count; miss count reaching LOSS_COUNT SHALL enter HUNT and deassert LOCKED the same cycle.
REQ-012 LOCKED output SHALL be high exactly while state is LOCKED.
REQ-013 In LOCKED, bits SHALL shift into the word register LSB first; DATA_VALID SHALL pulse one cycle per frame, 2 FAST_CLK cycles after the edge sampling bit FRAME_BITS-1 on DATA_IN.
REQ-014 DATA_WORD SHALL hold its value between strobes; DATA_VALID SHALL never pulse outside LOCKED, including the frame completing as lock is acquired.
REQ-015 FRAME_ERR SHALL be high with DATA_VALID if any bad event occurred inside that frame, else low.
REQ-016 SYNC_ERR_CNT SHALL saturate at 0xFFFF; ERR_CLR SHALL set it to 0 next cycle, with ERR_CLR winning over a simultaneous increment.

Reset
REQ-017 RST high SHALL asynchronously force state HUNT, all counters 0, DATA_WORD 0, DATA_VALID 0, FRAME_ERR 0, LOCKED 0, SYNC_ERR_CNT 0.
REQ-018 Reset mid-frame SHALL discard the partial word; after RST falls the block SHALL reacquire from HUNT.

Structure
REQ-019 Package radio_pkg SHALL hold the FSM state enum and default values for FRAME_BITS, LOCK_COUNT and LOSS_COUNT.
REQ-020 The FSM plus good/miss counters SHALL be one sub-module, radio_frame_lock; shifting, word output and the error counter SHALL stay in the top.

Verification
REQ-021 Clean stream, FRAME_BITS=8, words 0x00,0x01,0x02... -> LOCKED after 4 good boundaries; then DATA_VALID every 8 cycles, words consecutive, FRAME_ERR 0.
REQ-022 Once locked, suppress one SYNC -> SYNC_ERR_CNT=1, that frame FRAME_ERR=1, LOCKED stays 1; suppress two consecutive -> LOCKED=0 at second boundary, no DATA_VALID after.
REQ-023 Extra SYNC at bit 3 during VERIFY -> return to HUNT, lock needs 4 further good boundaries, no DATA_VALID meanwhile.
REQ-024 Hold SYNC_ERR_CNT at 0xFFFF, inject bad events -> stays 0xFFFF; ERR_CLR same cycle as bad event -> 0.
REQ-025 Assert RST mid-frame while locked -> all outputs 0 immediately; after release and 4 clean boundaries, lock regained and first word correct.
